// File: rtl/xor_multiport_ram.sv
// xor_multiport_ram: XOR-banked multi-write/multi-read RAM with post-reset clear,
// same-address write arbitration (highest port wins) and selectable read-during-write bypass.
module xor_multiport_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       wr_addr [WR_PORTS],
  input  logic [WIDTH-1:0]    wr_data [WR_PORTS],
  input  logic [WR_PORTS-1:0] wr_en,
  input  logic [AW-1:0]       rd_addr [RD_PORTS],
  output logic [WIDTH-1:0]    rd_q [RD_PORTS],
  output logic                ready,
  output logic                wr_conflict
);
  localparam int NB = WR_PORTS - 1 + RD_PORTS;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, conflict_q, conflict_d;
  logic [WIDTH-1:0] rdata_q [RD_PORTS];
  logic [WIDTH-1:0] rdata_d [RD_PORTS];
  // Each writer owns NB identical replicas: one per other writer, then one per read port.
  logic [WIDTH-1:0] mem [WR_PORTS][NB][DEPTH];
  logic [WR_PORTS-1:0] we, mem_we;
  logic [WIDTH-1:0] enc [WR_PORTS];
  logic [AW-1:0] waddr [WR_PORTS];
  always_comb begin
    for (int w = 0; w < WR_PORTS; w++) begin
      we[w] = state_q == RUN && wr_en[w];
      for (int v = w + 1; v < WR_PORTS; v++)
        if (wr_en[v] && wr_addr[v] == wr_addr[w]) we[w] = 1'b0;
    end
    conflict_d = state_q == RUN && |(wr_en & ~we);
    for (int w = 0; w < WR_PORTS; w++) begin
      enc[w] = wr_data[w];
      for (int o = 0; o < WR_PORTS; o++)
        if (o != w) enc[w] ^= mem[o][(w < o) ? w : w - 1][wr_addr[w]];
      enc[w] = state_q == CLEAR ? '0 : enc[w];
      waddr[w] = state_q == CLEAR ? cnt_q : wr_addr[w];
      mem_we[w] = rst_n && (state_q == CLEAR || we[w]);
    end
    for (int r = 0; r < RD_PORTS; r++) begin
      rdata_d[r] = '0;
      for (int w = 0; w < WR_PORTS; w++) rdata_d[r] ^= mem[w][WR_PORTS-1+r][rd_addr[r]];
      for (int w = 0; w < WR_PORTS; w++)
        if (BYPASS && we[w] && wr_addr[w] == rd_addr[r]) rdata_d[r] = wr_data[w];
      rdata_d[r] = state_q == RUN ? rdata_d[r] : '0;
    end
    state_d = (state_q == CLEAR && cnt_q == AW'(DEPTH - 1)) ? RUN : state_q;
    cnt_d = state_q == CLEAR ? cnt_q + 1'b1 : cnt_q;
    ready_d = state_d == RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      ready_q <= 1'b0;
      conflict_q <= 1'b0;
      for (int r = 0; r < RD_PORTS; r++) rdata_q[r] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      conflict_q <= conflict_d;
      for (int r = 0; r < RD_PORTS; r++) rdata_q[r] <= rdata_d[r];
    end
  end
  always_ff @(posedge clk)
    for (int w = 0; w < WR_PORTS; w++)
      if (mem_we[w])
        for (int j = 0; j < NB; j++) mem[w][j][waddr[w]] <= enc[w];
  assign rd_q = rdata_q;
  assign ready = ready_q;
  assign wr_conflict = conflict_q;
endmodule

// File: tb/tb_xor_multiport_ram.sv
// tb_xor_multiport_ram: drives BYPASS=1 and BYPASS=0 instances with identical stimulus
// and compares both against a word-array reference model.
module tb_xor_multiport_ram;
  localparam int W = 8, D = 16, AW = 4;
  logic clk, rst_n;
  logic [AW-1:0] wr_addr [2];
  logic [W-1:0] wr_data [2];
  logic [1:0] wr_en;
  logic [AW-1:0] rd_addr [2];
  logic [W-1:0] rd_q1 [2];
  logic [W-1:0] rd_q0 [2];
  logic ready1, ready0, conf1, conf0;
  int errors = 0, checks = 0;
  logic [W-1:0] model [D];
  int edges = 0;

  xor_multiport_ram #(.WIDTH(W), .DEPTH(D), .WR_PORTS(2), .RD_PORTS(2), .BYPASS(1'b1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_q(rd_q1), .ready(ready1), .wr_conflict(conf1));
  xor_multiport_ram #(.WIDTH(W), .DEPTH(D), .WR_PORTS(2), .RD_PORTS(2), .BYPASS(1'b0)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_q(rd_q0), .ready(ready0), .wr_conflict(conf0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic [W-1:0] e1 [2], input logic [W-1:0] e0 [2],
                               input logic er, input logic ec);
    check("ready_b1", ready1, er);
    check("ready_b0", ready0, er);
    check("conflict_b1", conf1, ec);
    check("conflict_b0", conf0, ec);
    for (int r = 0; r < 2; r++) begin
      check($sformatf("rd_q_b1[%0d]", r), rd_q1[r], e1[r]);
      check($sformatf("rd_q_b0[%0d]", r), rd_q0[r], e0[r]);
    end
  endtask

  // One clock edge: the model resolves the edge from the presented inputs, then outputs are compared.
  task automatic step();
    int hits [D];
    logic [W-1:0] nv [D];
    logic [W-1:0] e1 [2];
    logic [W-1:0] e0 [2];
    logic run, ec;
    run = edges >= D;
    ec = 1'b0;
    for (int a = 0; a < D; a++) begin hits[a] = 0; nv[a] = '0; end
    if (run)
      for (int w = 0; w < 2; w++)
        if (wr_en[w]) begin hits[wr_addr[w]]++; nv[wr_addr[w]] = wr_data[w]; end
    for (int a = 0; a < D; a++) if (hits[a] >= 2) ec = 1'b1;
    for (int r = 0; r < 2; r++) begin
      e0[r] = run ? model[rd_addr[r]] : '0;
      e1[r] = (run && hits[rd_addr[r]] > 0) ? nv[rd_addr[r]] : e0[r];
    end
    if (run) begin
      for (int a = 0; a < D; a++) if (hits[a] > 0) model[a] = nv[a];
    end else begin
      model[edges] = '0;
      edges++;
    end
    @(posedge clk);
    #1;
    check_outputs(e1, e0, edges >= D, ec);
  endtask

  task automatic idle();
    wr_en = 2'b00;
  endtask

  initial begin
    logic [W-1:0] z [2];
    z[0] = '0; z[1] = '0;
    for (int a = 0; a < D; a++) model[a] = '0;
    rst_n = 1'b0;
    wr_en = 2'b00;
    wr_addr[0] = '0; wr_addr[1] = '0; wr_data[0] = '0; wr_data[1] = '0;
    rd_addr[0] = 4'd3; rd_addr[1] = 4'd3;
    #8;
    check_outputs(z, z, 1'b0, 1'b0);
    #4 rst_n = 1'b1;
    // clear sequence with an ignored write at E10
    for (int i = 1; i <= D; i++) begin
      if (i == 10) begin wr_en = 2'b01; wr_addr[0] = 4'd10; wr_data[0] = 8'h55; end
      else idle();
      step();
    end
    idle(); rd_addr[0] = 4'd10; step();
    step();
    // basic write/read
    wr_en = 2'b01; wr_addr[0] = 4'd5; wr_data[0] = 8'd42; rd_addr[0] = 4'd0; step();
    idle(); rd_addr[1] = 4'd5; step();
    step();
    wr_en = 2'b10; wr_addr[1] = 4'd7; wr_data[1] = 8'h99; step();
    idle(); rd_addr[0] = 4'd7; rd_addr[1] = 4'd7; step();
    step();
    // collision
    wr_en = 2'b11; wr_addr[0] = 4'd9; wr_addr[1] = 4'd9; wr_data[0] = 8'h11; wr_data[1] = 8'h22; step();
    idle(); rd_addr[0] = 4'd9; step();
    step();
    // parallel distinct writes
    wr_en = 2'b11; wr_addr[0] = 4'd1; wr_addr[1] = 4'd2; wr_data[0] = 8'hA0; wr_data[1] = 8'hB0; step();
    idle(); rd_addr[0] = 4'd1; rd_addr[1] = 4'd2; step();
    step();
    // read-during-write
    wr_en = 2'b01; wr_addr[0] = 4'd4; wr_data[0] = 8'h10; step();
    wr_en = 2'b01; wr_data[0] = 8'h20; rd_addr[0] = 4'd4; step();
    idle(); step();
    // randomized traffic on a narrow address range to provoke collisions and bypass
    for (int i = 0; i < 150; i++) begin
      wr_en = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        wr_addr[p] = 4'($urandom_range(0, 5));
        wr_data[p] = 8'($urandom);
        rd_addr[p] = 4'($urandom_range(0, 5));
      end
      step();
    end
    wr_en = 2'b01; wr_addr[0] = 4'd5; wr_data[0] = 8'h6C; step();
    // asynchronous reset between edges
    idle(); rd_addr[0] = 4'd5; rd_addr[1] = 4'd5;
    #2 rst_n = 1'b0;
    #1;
    check_outputs(z, z, 1'b0, 1'b0);
    edges = 0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < D; i++) step();
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xor_multiport_ram.md
Name: xor_multiport_ram

Overview:
- Parametrised successor to the team's XOR distributed memory. Supports independent counts of write ports and read ports instead of a single combined port list.
- Storage is XOR-banked 1R1W distributed RAM. Each write port stores its data XOR-encoded against the other writers' banks. Each read port decodes by XORing one bank per writer.
- Adds the following on top of the plain memory:
  - hardware clear sequencer after reset;
  - same-address write arbitration with a conflict flag;
  - selectable read-during-write bypass.
- Used as the register-file and scoreboard storage in multi-issue datapaths.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 256, number of words. Power of two, at least 2. Address width is AW = $clog2(DEPTH).
- WR_PORTS, 2, number of write ports, at least 1.
- RD_PORTS, 2, number of read ports, at least 1.
- BYPASS, 1, read-during-write mode: 1 = read returns new data, 0 = read returns old data.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_addr  input  [AW-1:0] x WR_PORTS  write address per write port.
- wr_data  input  [WIDTH-1:0] x WR_PORTS  write data per write port.
- wr_en  input  1 x WR_PORTS  write enable per write port.
- rd_addr  input  [AW-1:0] x RD_PORTS  read address per read port.
- rd_q  output  [WIDTH-1:0] x RD_PORTS  registered read data per read port.
- ready  output  1  high when clearing is complete and writes are accepted.
- wr_conflict  output  1  registered pulse: two or more enabled writers targeted the same address in the previous cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_q = 0 on every port; ready = 0; wr_conflict = 0.
  - Clear counter = 0 and the state machine enters CLEAR.
  - Bank contents are not touched by reset itself.
- State machine: CLEAR -> RUN.
- CLEAR state:
  - The rising edges E1..E_DEPTH after rst_n deasserts write zero into address 0..DEPTH-1 of every bank.
  - ready goes high at edge E_DEPTH; the state becomes RUN.
  - Every wr_en is ignored and rd_q is held at 0 during CLEAR.
  - Writes presented before edge E_(DEPTH+1) have no effect.
- RUN state, reads:
  - Read latency is 1 cycle. rd_q[r] at edge N+1 equals the stored word at rd_addr[r] sampled at edge N.
  - Reads are unconditional every cycle; there is no read enable.
- RUN state, writes:
  - A write with wr_en[w]=1 is committed at the sampling edge.
  - A subsequent read issued at the next edge observes the written value.
- Write conflicts:
  - If several enabled writers share an address, the highest-indexed port wins.
  - Lower-indexed colliding writes are suppressed entirely; no XOR corruption of the stored word is allowed.
  - wr_conflict is high for exactly one cycle, the cycle after the colliding edge.
  - Writers to distinct addresses always all commit.
- Read-during-write (rd_addr equals an enabled wr_addr on the same edge):
  - BYPASS=1: rd_q returns the winning write data.
  - BYPASS=0: rd_q returns the previously stored word.
- Width and addressing:
  - Addresses are exactly AW bits; there is no out-of-range case.
  - Data is stored unmodified, with no sign or width extension.
- Reset mid-operation: rst_n low during RUN or CLEAR aborts immediately, re-enters CLEAR from address 0, and applies all reset output values. Previously stored data is lost after the re-clear.
- Bank structure: WR_PORTS x (WR_PORTS-1+RD_PORTS) banks, each DEPTH x WIDTH, with asynchronous internal read. The structure is implementation-visible only through resource count; it is not visible functionally.

Test Plan (WIDTH=8, DEPTH=16, WR_PORTS=2, RD_PORTS=2 unless noted):
- Clear sequence: release rst_n, read addr 3 on port 0 throughout.
  - ready rises at edge E16; rd_q[0]=0 throughout.
  - wr_en[0]=1 with data 0x55 presented at edge E10 is ignored: reading addr 10 after ready returns 0.
- Basic write/read: write 42 to addr 5 via port 0, then read addr 5 on port 1 the next cycle -> rd_q[1]=42 one edge later. Port 1 writes 0x99 to addr 7 -> both read ports return 0x99.
- Collision: port 0 writes 0x11 and port 1 writes 0x22, both to addr 9, same edge -> wr_conflict=1 for one cycle, then 0; reading addr 9 returns 0x22.
- Parallel writes to distinct addresses: port 0 writes 0xA0 to addr 1 and port 1 writes 0xB0 to addr 2, same edge -> wr_conflict stays 0; reads return 0xA0 and 0xB0.
- Bypass, with addr 4 holding 0x10 and a write of 0x20 to addr 4 while port 0 reads addr 4:
  - BYPASS=1 -> rd_q[0]=0x20.
  - BYPASS=0 -> rd_q[0]=0x10, then 0x20 on the next read.
- Reset mid-run: after writes from the earlier scenarios, pulse rst_n low for 3 ns between edges.
  - rd_q and ready drop to 0 immediately.
  - After 16 more edges ready=1 and addr 5 reads 0.
